// File: rtl/beezip_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
package beezip_arb_pkg;

   // Arbiter FSM: searching for a requester, or holding one until end of packet.
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Increment a requester index with explicit wrap at n (n need not be a power of two).
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with registered occupancy; full/empty depend only on state.
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok;
   logic          pop_ok;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign rdata = mem_q[rd_ptr_q];

   // Next pointers, occupancy and storage; a full FIFO refuses a push even when popping.
   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-way packet-atomic round-robin merge of valid/ready streams, one FIFO per requester.
module stream_rr_arbiter
   import beezip_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int ID_W  = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      in_valid,
   input  logic [N*W-1:0]    in_payload,
   input  logic [N-1:0]      in_last,
   output logic [N-1:0]      in_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_payload,
   output logic              out_last,
   output logic [ID_W-1:0]   out_id,
   input  logic              out_ready
);

   logic [W:0]      fifo_rdata [N];
   logic [N-1:0]    fifo_full;
   logic [N-1:0]    fifo_empty;
   logic [N-1:0]    fifo_pop;

   arb_state_t      state_q, state_d;
   logic [ID_W-1:0] grant_q, grant_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   logic            found;
   logic [ID_W-1:0] pick;
   logic [W:0]      head;
   logic            fire;

   for (genvar i = 0; i < N; i++) begin : g_fifo
      fifo #(
         .W     (W + 1),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (in_valid[i]),
         .wdata ({in_last[i], in_payload[i*W +: W]}),
         .pop   (fifo_pop[i]),
         .rdata (fifo_rdata[i]),
         .full  (fifo_full[i]),
         .empty (fifo_empty[i])
      );
   end

   assign in_ready = ~fifo_full;

   // Round-robin search: first non-empty FIFO starting at rr_ptr, wrapping at N.
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int unsigned k = 0; k < $unsigned(N); k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= $unsigned(N)) begin
            idx = idx - $unsigned(N);
         end
         if (!found && !fifo_empty[ID_W'(idx)]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Next state: lock onto the found requester, release only after the last beat is accepted.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (fire && head[W]) begin
               state_d  = IDLE;
               rr_ptr_d = ID_W'(rr_next(32'(grant_q), $unsigned(N)));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: present the granted FIFO head, zero when not valid, pop on handshake.
   always_comb begin
      head        = fifo_rdata[grant_q];
      out_valid   = (state_q == LOCKED) && !fifo_empty[grant_q];
      out_payload = '0;
      out_last    = 1'b0;
      out_id      = '0;
      if (out_valid) begin
         out_payload = head[W-1:0];
         out_last    = head[W];
         out_id      = grant_q;
      end
      fire     = out_valid && out_ready;
      fifo_pop = fire ? (N'(1) << grant_q) : '0;
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: directed scenarios plus a randomized traffic run.
module tb_stream_rr_arbiter;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int DEPTH = 4;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } sbeat_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   in_valid = '0;
   logic [N*W-1:0] in_payload = '0;
   logic [N-1:0]   in_last = '0;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_payload;
   logic           out_last;
   logic [1:0]     out_id;
   logic           out_ready = 1'b0;

   always #5 clk = ~clk;

   stream_rr_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_payload  (in_payload),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_payload (out_payload),
      .out_last    (out_last),
      .out_id      (out_id),
      .out_ready   (out_ready)
   );

   int     checks = 0;
   int     failures = 0;
   int     cyc = 0;
   beat_t  exp_q[$];
   sbeat_t sq[N][$];
   sbeat_t rq[N][$];
   bit     rand_valid = 0;
   bit     rand_ready = 0;
   bit     rand_chk = 0;
   bit     chk_gap = 0;
   bit     have_prev = 0;
   int     prev_fire = 0;
   bit     in_pkt = 0;
   logic [1:0] pkt_id = '0;
   int     rand_delivered = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=unexpected_beat id=%0d data=%0h required=no_beat", name, out_id, out_payload);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stim(input int r, input logic [7:0] d, input logic l);
      sbeat_t b;
      b.data = d;
      b.last = l;
      sq[r].push_back(b);
   endtask

   task automatic expect_beat(input logic [1:0] id, input logic [7:0] d, input logic l);
      beat_t e;
      e.id = id;
      e.data = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   function automatic bit queues_empty();
      bit e = (exp_q.size() == 0);
      for (int r = 0; r < N; r++) begin
         if (sq[r].size() != 0 || rq[r].size() != 0) e = 0;
      end
      return e;
   endfunction

   task automatic wait_drain(input int maxc, input string name);
      int  n;
      bit  done;
      n = 0;
      done = queues_empty();
      while (!done && n < maxc) begin
         tick();
         n++;
         done = queues_empty();
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s drain_timeout actual_pending=%0d required=0", name, exp_q.size());
      end
      tick();
      tick();
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus driver: presents queue heads, retires a beat when accepted.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         for (int r = 0; r < N; r++) begin
            if (sq[r].size() > 0 && (!rand_valid || $urandom_range(1, 0) == 1)) begin
               in_valid[r]          = 1'b1;
               in_payload[r*W +: W] = sq[r][0].data;
               in_last[r]           = sq[r][0].last;
            end else begin
               in_valid[r]          = 1'b0;
               in_payload[r*W +: W] = '0;
               in_last[r]           = 1'b0;
            end
         end
         if (rand_ready) out_ready = ($urandom_range(1, 0) == 1);
         @(negedge clk);
         for (int r = 0; r < N; r++) begin
            if (rst_n && in_valid[r] && in_ready[r]) void'(sq[r].pop_front());
         end
      end
   end

   // Monitor: compares each accepted output beat against the scoreboard.
   always @(negedge clk) begin
      beat_t  e;
      sbeat_t b;
      if (!rst_n) begin
         in_pkt = 0;
      end else if (out_valid && out_ready) begin
         if (in_pkt) chk("no_interleave", 32'(out_id), 32'(pkt_id));
         if (chk_gap) begin
            if (have_prev) chk("rr_bubble", cyc - prev_fire, 2);
            prev_fire = cyc;
            have_prev = 1;
         end
         if (rand_chk) begin
            if (rq[out_id].size() == 0) begin
               fail_now("rand_extra_beat");
            end else begin
               b = rq[out_id].pop_front();
               chk("rand_data", 32'(out_payload), 32'(b.data));
               chk("rand_last", 32'(out_last), 32'(b.last));
               rand_delivered++;
            end
         end else begin
            if (exp_q.size() == 0) begin
               fail_now("dir_extra_beat");
            end else begin
               e = exp_q.pop_front();
               chk("dir_id", 32'(out_id), 32'(e.id));
               chk("dir_data", 32'(out_payload), 32'(e.data));
               chk("dir_last", 32'(out_last), 32'(e.last));
            end
         end
         in_pkt = !out_last;
         pkt_id = out_id;
      end
   end

   initial begin
      int total;
      int r;
      int len;
      sbeat_t sb;
      bit hit;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 32'hF);
      chk("rst_out_id", 32'(out_id), 0);
      chk("rst_out_payload", 32'(out_payload), 0);
      chk("rst_out_last", 32'(out_last), 0);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Single beat latency on requester 2
      stim(2, 8'hA5, 1'b1);
      expect_beat(2'd2, 8'hA5, 1'b1);
      tick();
      chk("lat_c1_valid", 32'(out_valid), 0);
      tick();
      chk("lat_c2_valid", 32'(out_valid), 1);
      chk("lat_c2_id", 32'(out_id), 2);
      chk("lat_c2_data", 32'(out_payload), 32'hA5);
      chk("lat_c2_last", 32'(out_last), 1);
      tick();
      chk("lat_c3_valid", 32'(out_valid), 0);
      wait_drain(20, "single");

      // rr_ptr is now 3: requester 3 wins over requester 0
      stim(0, 8'h30, 1'b1);
      stim(3, 8'h33, 1'b1);
      expect_beat(2'd3, 8'h33, 1'b1);
      expect_beat(2'd0, 8'h30, 1'b1);
      wait_drain(50, "rr_ptr_after_single");

      // Fairness: rr_ptr is 1, all requesters keep single-beat packets queued
      have_prev = 0;
      chk_gap = 1;
      for (int k = 0; k < 25; k++) begin
         for (int q = 0; q < N; q++) stim(q, 8'(q), 1'b1);
      end
      for (int j = 0; j < 100; j++) expect_beat(2'((1 + j) % 4), 8'((1 + j) % 4), 1'b1);
      wait_drain(600, "fairness");
      chk_gap = 0;

      // Atomicity: requester 1 stalls mid-packet while requester 0 is full
      stim(1, 8'h10, 1'b0);
      stim(1, 8'h11, 1'b0);
      for (int k = 0; k < 4; k++) stim(0, 8'(8'h20 + k), (k == 3));
      expect_beat(2'd1, 8'h10, 1'b0);
      expect_beat(2'd1, 8'h11, 1'b0);
      expect_beat(2'd1, 8'h12, 1'b1);
      for (int k = 0; k < 4; k++) expect_beat(2'd0, 8'(8'h20 + k), (k == 3));
      hit = 0;
      for (int n = 0; n < 30 && !hit; n++) begin
         if (exp_q.size() == 5) hit = 1;
         else tick();
      end
      chk("atom_first_two_delivered", 32'(hit), 1);
      for (int k = 0; k < 4; k++) begin
         chk("atom_gap_valid", 32'(out_valid), 0);
         chk("atom_req0_full", 32'(in_ready[0]), 0);
         tick();
      end
      stim(1, 8'h12, 1'b1);
      wait_drain(60, "atomicity");

      // Backpressure: requester 3 fills its FIFO while downstream stalls
      out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         stim(3, 8'(k), (k == 6));
         expect_beat(2'd3, 8'(k), (k == 6));
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         if (out_valid) begin
            chk("bp_hold_data", 32'(out_payload), 1);
            chk("bp_hold_id", 32'(out_id), 3);
         end
      end
      chk("bp_in_ready3", 32'(in_ready[3]), 0);
      chk("bp_pending_beats", sq[3].size(), 2);
      chk("bp_out_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      wait_drain(60, "backpressure");

      // Reset mid-packet on requester 2 after two beats
      for (int k = 0; k < 5; k++) stim(2, 8'(8'h50 + k), (k == 4));
      expect_beat(2'd2, 8'h50, 1'b0);
      expect_beat(2'd2, 8'h51, 1'b0);
      hit = 0;
      for (int n = 0; n < 30 && !hit; n++) begin
         if (exp_q.size() == 0) hit = 1;
         else tick();
      end
      chk("rst_mid_two_delivered", 32'(hit), 1);
      out_ready = 1'b0;
      rst_n = 1'b0;
      sq[2].delete();
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      chk("rst_mid_out_valid", 32'(out_valid), 0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'hF);
      // rr_ptr back to 0: requester 0 beats requester 3
      stim(0, 8'h60, 1'b0);
      stim(0, 8'h61, 1'b1);
      stim(3, 8'h63, 1'b1);
      expect_beat(2'd0, 8'h60, 1'b0);
      expect_beat(2'd0, 8'h61, 1'b1);
      expect_beat(2'd3, 8'h63, 1'b1);
      wait_drain(60, "after_reset");

      // Random traffic: per-requester order, no interleave, exactly-once delivery
      rand_chk = 1;
      total = 0;
      while (total < 6000) begin
         r = $urandom_range(N - 1, 0);
         len = $urandom_range(8, 1);
         for (int k = 0; k < len; k++) begin
            sb.data = 8'($urandom);
            sb.last = (k == len - 1);
            sq[r].push_back(sb);
            rq[r].push_back(sb);
         end
         total += len;
      end
      rand_valid = 1;
      rand_ready = 1;
      wait_drain(60000, "random");
      rand_valid = 0;
      rand_ready = 0;
      out_ready = 1'b1;
      chk("rand_delivered_count", rand_delivered, total);
      rand_chk = 0;
      chk("final_expect_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
